rr_grant_arbiter: RTL and testbench

RR_GRANT_ARBITER -- requirements
Module: rr_grant_arbiter

---
 rtl/rr_grant_arbiter_pkg.sv | 21 ++
 rtl/rr_grant_arbiter_ffs_oh.sv | 38 +++
 rtl/rr_grant_arbiter.sv | 127 ++++++++++++
 tb/tb_rr_grant_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_grant_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rr_grant_arbiter_pkg
//  Purpose  : Shared definitions for the round-robin grant arbiter:
//             arbiter state encoding and the requester-count upper bound.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package rr_grant_arbiter_pkg;

    // Upper bound on the number of requesters the arbiter supports.
    localparam int unsigned C_N_INPUT_MAX = 64;

    // IDLE: no grant outstanding. GRANT: gnt_o carries a valid one-hot grant.
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

endpackage : rr_grant_arbiter_pkg
`default_nettype wire

// File: rtl/rr_grant_arbiter_ffs_oh.sv
`default_nettype none
// ============================================================================
//  Module   : rr_ffs_oh
//  Purpose  : Combinational wrapping find-first-set. Returns, one-hot, the
//             first set bit of i_req at or above the one-hot pointer i_prio,
//             wrapping from bit N_INPUT-1 back to bit 0. Zero if i_req is zero.
//  Ports    : i_req  [N_INPUT-1:0] candidate vector
//             i_prio [N_INPUT-1:0] one-hot priority pointer
//             o_gnt  [N_INPUT-1:0] one-hot winner (or zero)
//  Revision : 1.0 - initial release
// ============================================================================
module rr_ffs_oh #(
    parameter int N_INPUT = 4
) (
    input  logic [N_INPUT-1:0] i_req,
    input  logic [N_INPUT-1:0] i_prio,
    output logic [N_INPUT-1:0] o_gnt
);

    logic [N_INPUT-1:0] w_upper_mask;
    logic [N_INPUT-1:0] w_masked;
    logic [N_INPUT-1:0] w_masked_lsb;
    logic [N_INPUT-1:0] w_req_lsb;

    // prio - 1 sets every bit below the pointer; inverting it keeps the
    // pointer bit and everything above it.
    assign w_upper_mask = ~(i_prio - N_INPUT'(1));
    assign w_masked     = i_req & w_upper_mask;

    // x & -x isolates the lowest set bit.
    assign w_masked_lsb = w_masked & (~w_masked + N_INPUT'(1));
    assign w_req_lsb    = i_req & (~i_req + N_INPUT'(1));

    // Nothing at or above the pointer: wrap and take the lowest request.
    assign o_gnt = (|w_masked) ? w_masked_lsb : w_req_lsb;

endmodule : rr_ffs_oh
`default_nettype wire

// File: rtl/rr_grant_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_grant_arbiter
//  Purpose  : Round-robin arbiter with a registered one-hot grant and a
//             valid/ready handshake. One grant per cycle back-to-back; the
//             priority pointer rotates past each accepted winner.
//  Ports    : clk          sole clock, rising edge
//             rstn         synchronous active-low reset
//             req_i        [N_INPUT-1:0] per-requester request
//             gnt_o        [N_INPUT-1:0] registered one-hot grant
//             gnt_valid_o  grant present on gnt_o
//             gnt_ready_i  consumer accepts the grant
//             lock_i       winner asks to keep the grant (RR_ARB_LOCK_EN only)
//  Config   : RR_ARB_LOCK_EN - adds lock_i and grant retention on handshake
//  Revision : 1.0 - initial release
// ============================================================================
module rr_grant_arbiter
    import rr_grant_arbiter_pkg::*;
#(
    parameter int N_INPUT = 4
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [N_INPUT-1:0] req_i,
    output logic [N_INPUT-1:0] gnt_o,
    output logic               gnt_valid_o,
`ifdef RR_ARB_LOCK_EN
    input  logic               lock_i,
`endif
    input  logic               gnt_ready_i
);

    // Elaboration-time guard on the requester count.
    if ((N_INPUT < 1) || (N_INPUT > C_N_INPUT_MAX)) begin : g_bad_n_input
        $error("rr_grant_arbiter: N_INPUT out of range");
    end

    arb_state_t         r_state;
    logic [N_INPUT-1:0] r_gnt;
    logic [N_INPUT-1:0] r_prio;

    logic [N_INPUT-1:0] w_gnt_rot;
    logic [N_INPUT-1:0] w_arb_req;
    logic [N_INPUT-1:0] w_arb_prio;
    logic [N_INPUT-1:0] w_winner;
    logic               w_in_grant;
    logic               w_hs;
    logic               w_lock_hold;

    // Current grant rotated left by one: the pointer after an acceptance.
    if (N_INPUT == 1) begin : g_rot_single
        assign w_gnt_rot = r_gnt;
    end else begin : g_rot_multi
        assign w_gnt_rot = {r_gnt[N_INPUT-2:0], r_gnt[N_INPUT-1]};
    end

    assign w_in_grant = (r_state == ST_GRANT);
    assign w_hs       = w_in_grant & gnt_ready_i;

`ifdef RR_ARB_LOCK_EN
    // Retention only makes sense while the winner is still requesting.
    assign w_lock_hold = w_hs & lock_i & (|(req_i & r_gnt));
`else
    assign w_lock_hold = 1'b0;
`endif

    // In GRANT the next winner is chosen against the already-rotated pointer
    // and excludes the requester just served; in IDLE the stored pointer is
    // used directly. One search instance serves both cases.
    assign w_arb_req  = w_in_grant ? (req_i & ~r_gnt) : req_i;
    assign w_arb_prio = w_in_grant ? w_gnt_rot : r_prio;

    rr_ffs_oh #(
        .N_INPUT (N_INPUT)
    ) u_ffs (
        .i_req  (w_arb_req),
        .i_prio (w_arb_prio),
        .o_gnt  (w_winner)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_prio  <= N_INPUT'(1);
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|req_i) begin
                        r_state <= ST_GRANT;
                        r_gnt   <= w_winner;
                    end
                end
                ST_GRANT: begin
                    // Without a handshake (or under lock) everything holds.
                    if (w_hs && !w_lock_hold) begin
                        r_prio <= w_gnt_rot;
                        if (|w_arb_req) begin
                            r_gnt <= w_winner;
                        end else begin
                            r_state <= ST_IDLE;
                            r_gnt   <= '0;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_gnt   <= '0;
                end
            endcase
        end
    end

    assign gnt_o       = r_gnt;
    assign gnt_valid_o = w_in_grant;

`ifndef SYNTHESIS
    // A granted requester must keep requesting until its grant is accepted.
    a_req_held_until_hs : assert property (@(posedge clk) disable iff (!rstn)
        (w_in_grant && !gnt_ready_i) |-> |(req_i & r_gnt));

    a_gnt_onehot0 : assert property (@(posedge clk) disable iff (!rstn)
        $onehot0(r_gnt));
`endif

endmodule : rr_grant_arbiter
`default_nettype wire

// File: tb/tb_rr_grant_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rr_grant_arbiter
//  Purpose  : Directed self-checking bench for rr_grant_arbiter (N_INPUT=4),
//             plus a protocol-respecting random run checking one-hot and the
//             starvation bound. Lock scenario built when RR_ARB_LOCK_EN set.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rr_grant_arbiter;

    localparam int N = 4;

    logic         clk;
    logic         rstn;
    logic [N-1:0] req_i;
    logic [N-1:0] gnt_o;
    logic         gnt_valid_o;
    logic         gnt_ready_i;
`ifdef RR_ARB_LOCK_EN
    logic         lock_i;
`endif

    int n_checks;
    int n_fail;

    rr_grant_arbiter #(
        .N_INPUT (N)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .req_i       (req_i),
        .gnt_o       (gnt_o),
        .gnt_valid_o (gnt_valid_o),
`ifdef RR_ARB_LOCK_EN
        .lock_i      (lock_i),
`endif
        .gnt_ready_i (gnt_ready_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rstn        = 1'b0;
        req_i       = '0;
        gnt_ready_i = 1'b0;
`ifdef RR_ARB_LOCK_EN
        lock_i      = 1'b0;
`endif
        tick();
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        rstn        = 1'b0;
        req_i       = 4'b1111;
        gnt_ready_i = 1'b1;
`ifdef RR_ARB_LOCK_EN
        lock_i      = 1'b0;
`endif
        repeat (2) tick();
        n_checks++;
        if (gnt_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid: got %b expected 0", gnt_valid_o);
        end
        n_checks++;
        if (gnt_o !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_gnt: got %b expected 0000", gnt_o);
        end
        req_i = '0;
        rstn  = 1'b1;
        tick();
        n_checks++;
        if (gnt_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_no_req: got valid %b expected 0", gnt_valid_o);
        end
    endtask

    // All requesting, consumer always ready: strict rotation one per cycle.
    task automatic test_rotate();
        logic [N-1:0] exp_seq [5];
        exp_seq[0] = 4'b0001;
        exp_seq[1] = 4'b0010;
        exp_seq[2] = 4'b0100;
        exp_seq[3] = 4'b1000;
        exp_seq[4] = 4'b0001;
        apply_reset();
        req_i       = 4'b1111;
        gnt_ready_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (gnt_valid_o !== 1'b1 || gnt_o !== exp_seq[i]) begin
                n_fail++;
                $display("FAIL rotate[%0d]: got valid %b gnt %b expected valid 1 gnt %b",
                         i, gnt_valid_o, gnt_o, exp_seq[i]);
            end
        end
    endtask

    // Grant holds while not ready even as requests change; then wrap-around.
    task automatic test_hold_and_wrap();
        apply_reset();
        req_i       = 4'b0100;
        gnt_ready_i = 1'b0;
        tick();
        n_checks++;
        if (gnt_valid_o !== 1'b1 || gnt_o !== 4'b0100) begin
            n_fail++;
            $display("FAIL hold_first: got valid %b gnt %b expected valid 1 gnt 0100",
                     gnt_valid_o, gnt_o);
        end
        req_i = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (gnt_valid_o !== 1'b1 || gnt_o !== 4'b0100) begin
                n_fail++;
                $display("FAIL hold[%0d]: got valid %b gnt %b expected valid 1 gnt 0100",
                         i, gnt_valid_o, gnt_o);
            end
        end
        gnt_ready_i = 1'b1;
        tick();
        n_checks++;
        if (gnt_o !== 4'b1000) begin
            n_fail++;
            $display("FAIL after_hold: got %b expected 1000", gnt_o);
        end
        // Requester 3 keeps its request through acceptance, then 0/1 remain.
        req_i = 4'b1011;
        tick();
        n_checks++;
        if (gnt_o !== 4'b0001) begin
            n_fail++;
            $display("FAIL wrap_first: got %b expected 0001", gnt_o);
        end
        req_i = 4'b0011;
        tick();
        n_checks++;
        if (gnt_o !== 4'b0010) begin
            n_fail++;
            $display("FAIL wrap_second: got %b expected 0010", gnt_o);
        end
        req_i = 4'b0000;
        tick();
        n_checks++;
        if (gnt_valid_o !== 1'b0 || gnt_o !== 4'b0000) begin
            n_fail++;
            $display("FAIL drain_idle: got valid %b gnt %b expected valid 0 gnt 0000",
                     gnt_valid_o, gnt_o);
        end
    endtask

    // Reset in the middle of an unaccepted grant.
    task automatic test_reset_mid_grant();
        apply_reset();
        req_i       = 4'b1111;
        gnt_ready_i = 1'b1;
        tick();                 // 0001
        tick();                 // 0010, pointer now at 1
        gnt_ready_i = 1'b0;
        n_checks++;
        if (gnt_o !== 4'b0010) begin
            n_fail++;
            $display("FAIL mid_setup: got %b expected 0010", gnt_o);
        end
        rstn = 1'b0;
        tick();
        n_checks++;
        if (gnt_valid_o !== 1'b0 || gnt_o !== 4'b0000) begin
            n_fail++;
            $display("FAIL mid_reset: got valid %b gnt %b expected valid 0 gnt 0000",
                     gnt_valid_o, gnt_o);
        end
        rstn  = 1'b1;
        req_i = 4'b0110;
        tick();
        n_checks++;
        if (gnt_valid_o !== 1'b1 || gnt_o !== 4'b0010) begin
            n_fail++;
            $display("FAIL post_reset_grant: got valid %b gnt %b expected valid 1 gnt 0010",
                     gnt_valid_o, gnt_o);
        end
    endtask

    // Pointer must return to requester 0 on reset: 1001 after reset -> 0001.
    task automatic test_reset_prio();
        apply_reset();
        req_i       = 4'b1111;
        gnt_ready_i = 1'b1;
        repeat (3) tick();      // 0001, 0010, 0100
        gnt_ready_i = 1'b0;
        rstn        = 1'b0;
        tick();
        rstn  = 1'b1;
        req_i = 4'b1001;
        tick();
        n_checks++;
        if (gnt_o !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset_prio: got %b expected 0001", gnt_o);
        end
    endtask

    // Single request accepted, request removed -> back to IDLE.
    task automatic test_single();
        apply_reset();
        req_i       = 4'b0001;
        gnt_ready_i = 1'b1;
        tick();
        n_checks++;
        if (gnt_valid_o !== 1'b1 || gnt_o !== 4'b0001) begin
            n_fail++;
            $display("FAIL single_grant: got valid %b gnt %b expected valid 1 gnt 0001",
                     gnt_valid_o, gnt_o);
        end
        req_i = 4'b0000;
        tick();
        n_checks++;
        if (gnt_valid_o !== 1'b0 || gnt_o !== 4'b0000) begin
            n_fail++;
            $display("FAIL single_idle: got valid %b gnt %b expected valid 0 gnt 0000",
                     gnt_valid_o, gnt_o);
        end
    endtask

`ifdef RR_ARB_LOCK_EN
    task automatic test_lock();
        apply_reset();
        req_i       = 4'b0011;
        gnt_ready_i = 1'b1;
        lock_i      = 1'b1;
        tick();
        n_checks++;
        if (gnt_o !== 4'b0001) begin
            n_fail++;
            $display("FAIL lock_first: got %b expected 0001", gnt_o);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (gnt_valid_o !== 1'b1 || gnt_o !== 4'b0001) begin
                n_fail++;
                $display("FAIL lock_hold[%0d]: got valid %b gnt %b expected valid 1 gnt 0001",
                         i, gnt_valid_o, gnt_o);
            end
        end
        lock_i = 1'b0;
        tick();
        n_checks++;
        if (gnt_o !== 4'b0010) begin
            n_fail++;
            $display("FAIL lock_release: got %b expected 0010", gnt_o);
        end
    endtask
`endif

    // Sticky random requests (held until accepted), random ready. Checks
    // grant shape every cycle and that a waiting requester sees at most
    // N-1 other acceptances before its own.
    task automatic test_random();
        logic [N-1:0] g;
        logic         v;
        int           wait_cnt [N];
        apply_reset();
        for (int j = 0; j < N; j++) wait_cnt[j] = 0;
        req_i       = 4'($urandom_range(0, 15));
        gnt_ready_i = 1'b1;
        for (int c = 0; c < 300; c++) begin
            v = gnt_valid_o;
            g = gnt_o;
            tick();
            if (v && gnt_ready_i) begin
                for (int j = 0; j < N; j++) begin
                    if (req_i[j]) begin
                        if (g[j]) begin
                            wait_cnt[j] = 0;
                        end else begin
                            wait_cnt[j]++;
                            n_checks++;
                            if (wait_cnt[j] > N - 1) begin
                                n_fail++;
                                $display("FAIL starvation: requester %0d waited %0d handshakes, limit %0d",
                                         j, wait_cnt[j], N - 1);
                            end
                        end
                    end
                end
            end
            n_checks++;
            if (gnt_valid_o ? !$onehot(gnt_o) : (gnt_o !== 4'b0000)) begin
                n_fail++;
                $display("FAIL rand_shape[%0d]: got valid %b gnt %b expected one-hot when valid else 0000",
                         c, gnt_valid_o, gnt_o);
            end
            req_i       = (req_i & ~((v && gnt_ready_i) ? g : 4'b0000))
                        | (4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)));
            gnt_ready_i = ($urandom_range(0, 3) != 0);
        end
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rstn        = 1'b0;
        req_i       = '0;
        gnt_ready_i = 1'b0;
`ifdef RR_ARB_LOCK_EN
        lock_i      = 1'b0;
`endif
        test_reset();
        test_rotate();
        test_hold_and_wrap();
        test_reset_mid_grant();
        test_reset_prio();
        test_single();
`ifdef RR_ARB_LOCK_EN
        test_lock();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_rr_grant_arbiter
`default_nettype wire
